// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer-width helper and status-bit ordering for FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int awid_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Status vector order {udf_sticky, ovf_sticky, almost_empty, almost_full, empty, full}
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_AFULL  = 2;
    localparam int STAT_AEMPTY = 3;
    localparam int STAT_OVF    = 4;
    localparam int STAT_UDF    = 5;
    localparam int STAT_W      = 6;

endpackage

`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
// ============================================================================
// Module      : fifo_wrap_ptr
// Description : Pointer register with increment enable and modulo-DEPTH wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = awid_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_INC  = AW'(1);

    logic [AW-1:0] r_ptr;

    // Explicit wrap so non-power-of-2 depths never index past the array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + c_INC;
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/syncfifo_flags.sv
// ============================================================================
// Module      : syncfifo_flags
// Description : Single-clock FWFT FIFO with almost flags, sticky errors and
//               optional registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module syncfifo_flags
    import fifo_pkg::*;
#(
    parameter int WID    = 32,
    parameter int DEPTH  = 8,
    parameter int REGOUT = 0,
    parameter int AWID   = awid_of(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            softreset,
    input  logic            validin,
    input  logic [WID-1:0]  datain,
    output logic            full,
    input  logic            readout,
    output logic [WID-1:0]  dataout,
    output logic            empty,
    output logic [AWID:0]   count,
    input  logic [AWID:0]   afull_thr,
    input  logic [AWID:0]   aempty_thr,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow,
    output logic            ovf_sticky,
    output logic            udf_sticky,
    input  logic            clear_err
);

    // With a registered head, one entry lives outside the RAM
    localparam int c_RAMD = ((REGOUT != 0) && (DEPTH > 1)) ? DEPTH - 1 : DEPTH;
    localparam int c_PW   = awid_of(c_RAMD);

    localparam logic [AWID:0] c_FULLCNT = (AWID + 1)'(DEPTH);
    localparam logic [AWID:0] c_ONE     = (AWID + 1)'(1);
    localparam logic [AWID:0] c_TWO     = (AWID + 1)'(2);

    logic [WID-1:0]  r_mem [c_RAMD];
    logic [AWID:0]   r_count;
    logic            r_ovf_sticky;
    logic            r_udf_sticky;
    logic [c_PW-1:0] w_wptr;
    logic [c_PW-1:0] w_rptr;
    logic            w_wr;
    logic            w_rd;
    logic            w_ram_wr;
    logic            w_ram_rd;
    logic            w_clr;

    assign full  = (r_count == c_FULLCNT);
    assign empty = (r_count == '0);
    assign w_wr  = validin && !full;
    assign w_rd  = readout && !empty;
    assign w_clr = clear_err || softreset;

    fifo_wrap_ptr #(.DEPTH(c_RAMD), .AW(c_PW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (softreset),
        .i_inc (w_ram_wr),
        .o_ptr (w_wptr)
    );

    fifo_wrap_ptr #(.DEPTH(c_RAMD), .AW(c_PW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (softreset),
        .i_inc (w_ram_rd),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_wptr] <= datain;
        end
    end

    generate
        if (REGOUT != 0) begin : g_regout
            logic [WID-1:0] r_head;
            logic           w_head_ld;

            // Bypass the RAM when the written word becomes the new head
            assign w_head_ld = w_wr && ((r_count == '0) || ((r_count == c_ONE) && w_rd));
            assign w_ram_wr  = w_wr && !w_head_ld;
            assign w_ram_rd  = w_rd && (r_count >= c_TWO);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_head <= '0;
                end else if (softreset) begin
                    r_head <= '0;
                end else if (w_head_ld) begin
                    r_head <= datain;
                end else if (w_ram_rd) begin
                    r_head <= r_mem[w_rptr];
                end
            end

            assign dataout = r_head;
        end else begin : g_comb
            assign w_ram_wr = w_wr;
            assign w_ram_rd = w_rd;
            assign dataout  = r_mem[w_rptr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (softreset) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear in the same cycle as a fresh error wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else if (w_clr) begin
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else begin
            r_ovf_sticky <= r_ovf_sticky || overflow;
            r_udf_sticky <= r_udf_sticky || underflow;
        end
    end

    assign count        = r_count;
    assign almost_full  = (r_count >= afull_thr);
    assign almost_empty = (r_count <= aempty_thr);
    assign overflow     = validin && full;
    assign underflow    = readout && empty;
    assign ovf_sticky   = r_ovf_sticky;
    assign udf_sticky   = r_udf_sticky;

    a_cfg_depth: assert property (@(posedge clk) disable iff (!rst_n) (DEPTH >= 2))
        else $error("syncfifo_flags: DEPTH must be at least 2");

endmodule

`default_nettype wire

// File: tb/tb_syncfifo_flags.sv
// ============================================================================
// Module      : tb_syncfifo_flags
// Description : Scoreboard bench for a DEPTH=5 combinational-output FIFO and a
//               DEPTH=3 registered-output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syncfifo_flags;

    logic clk;
    logic rst_n;

    // Instance A: DEPTH=5, REGOUT=0
    logic        a_soft, a_vin, a_rd, a_clr;
    logic [31:0] a_din, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf, a_ovfs, a_udfs;
    logic [3:0]  a_count, a_afthr, a_aethr;

    // Instance B: DEPTH=3, REGOUT=1
    logic        b_soft, b_vin, b_rd, b_clr;
    logic [31:0] b_din, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf, b_ovfs, b_udfs;
    logic [2:0]  b_count, b_afthr, b_aethr;

    int          n_checks;
    int          n_fail;
    int          ma_cnt;
    int          mb_cnt;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    syncfifo_flags #(.WID(32), .DEPTH(5), .REGOUT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .softreset(a_soft), .validin(a_vin), .datain(a_din),
        .full(a_full), .readout(a_rd), .dataout(a_dout), .empty(a_empty), .count(a_count),
        .afull_thr(a_afthr), .aempty_thr(a_aethr), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_udf), .ovf_sticky(a_ovfs), .udf_sticky(a_udfs),
        .clear_err(a_clr)
    );

    syncfifo_flags #(.WID(32), .DEPTH(3), .REGOUT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .softreset(b_soft), .validin(b_vin), .datain(b_din),
        .full(b_full), .readout(b_rd), .dataout(b_dout), .empty(b_empty), .count(b_count),
        .afull_thr(b_afthr), .aempty_thr(b_aethr), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_udf), .ovf_sticky(b_ovfs), .udf_sticky(b_udfs),
        .clear_err(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later or 1 ns after the rising edge
    task automatic a_drive(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        a_vin = v; a_din = d; a_rd = r;
        #1;
    endtask

    task automatic a_tick();
        logic wr, rd;
        wr = a_vin && (ma_cnt < 5);
        rd = a_rd && (ma_cnt > 0);
        if (a_soft) begin
            qa.delete();
            ma_cnt = 0;
        end else begin
            if (rd) void'(qa.pop_front());
            if (wr) qa.push_back(a_din);
            ma_cnt = ma_cnt + int'(wr) - int'(rd);
        end
        @(posedge clk);
        #1;
        a_vin = 1'b0; a_rd = 1'b0; a_soft = 1'b0; a_clr = 1'b0;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        b_vin = v; b_din = d; b_rd = r;
        #1;
    endtask

    task automatic b_tick();
        logic wr, rd;
        wr = b_vin && (mb_cnt < 3);
        rd = b_rd && (mb_cnt > 0);
        if (rd) void'(qb.pop_front());
        if (wr) qb.push_back(b_din);
        mb_cnt = mb_cnt + int'(wr) - int'(rd);
        @(posedge clk);
        #1;
        b_vin = 1'b0; b_rd = 1'b0; b_soft = 1'b0; b_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_a_empty: got %b expected 1", a_empty); end
        n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_a_full: got %b expected 0", a_full); end
        n_checks++; if (a_count !== 4'd0) begin n_fail++; $display("FAIL reset_a_count: got %0d expected 0", a_count); end
        n_checks++; if (a_ae !== 1'b1) begin n_fail++; $display("FAIL reset_a_aempty: got %b expected 1", a_ae); end
        n_checks++; if (a_af !== 1'b0) begin n_fail++; $display("FAIL reset_a_afull: got %b expected 0", a_af); end
        n_checks++; if ({a_ovfs, a_udfs} !== 2'b00) begin n_fail++; $display("FAIL reset_a_sticky: got %b expected 00", {a_ovfs, a_udfs}); end
        n_checks++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL reset_b_empty: got %b expected 1", b_empty); end
        n_checks++; if (b_dout !== 32'h0) begin n_fail++; $display("FAIL reset_b_head: got %0h expected 0", b_dout); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) begin
            a_drive(1'b1, 32'hA0 + i, 1'b0);
            a_tick();
            n_checks++; if (a_count !== 4'(ma_cnt)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, a_count, ma_cnt); end
            n_checks++; if (a_ae !== (ma_cnt <= 1)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, a_ae, (ma_cnt <= 1)); end
            n_checks++; if (a_af !== (ma_cnt >= 4)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, a_af, (ma_cnt >= 4)); end
            n_checks++; if (a_full !== (ma_cnt == 5)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, a_full, (ma_cnt == 5)); end
        end
        a_drive(1'b1, 32'hA5, 1'b0);
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", a_ovf); end
        a_tick();
        n_checks++; if (a_ovfs !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", a_ovfs); end
        n_checks++; if (a_count !== 4'd5) begin n_fail++; $display("FAIL ovf_count: got %0d expected 5", a_count); end
        a_drive(1'b0, 32'h0, 1'b0);
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got %b expected 0", a_ovf); end
        a_tick();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 5; i++) begin
            a_drive(1'b0, 32'h0, 1'b1);
            n_checks++; if (a_dout !== qa[0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, a_dout, qa[0]); end
            a_tick();
            n_checks++; if (a_count !== 4'(ma_cnt)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, a_count, ma_cnt); end
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", a_empty); end
        a_drive(1'b0, 32'h0, 1'b0);
        a_clr = 1'b1;
        a_tick();
        n_checks++; if (a_ovfs !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", a_ovfs); end
    endtask

    task automatic test_back_to_back();
        a_drive(1'b1, 32'hB0, 1'b0); a_tick();
        a_drive(1'b1, 32'hB1, 1'b0); a_tick();
        for (int i = 0; i < 23; i++) begin
            a_drive(1'b1, 32'hC0 + i, 1'b1);
            n_checks++; if (a_dout !== qa[0]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, a_dout, qa[0]); end
            n_checks++; if ({a_ovf, a_udf} !== 2'b00) begin n_fail++; $display("FAIL b2b_pulse[%0d]: got %b expected 00", i, {a_ovf, a_udf}); end
            a_tick();
            n_checks++; if (a_count !== 4'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, a_count); end
        end
        n_checks++; if ({a_ovfs, a_udfs} !== 2'b00) begin n_fail++; $display("FAIL b2b_sticky: got %b expected 00", {a_ovfs, a_udfs}); end
        for (int i = 0; i < 2; i++) begin
            a_drive(1'b0, 32'h0, 1'b1);
            n_checks++; if (a_dout !== qa[0]) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %0h expected %0h", i, a_dout, qa[0]); end
            a_tick();
        end
    endtask

    task automatic test_regout();
        b_drive(1'b1, 32'h11, 1'b0);
        b_tick();
        n_checks++; if (b_empty !== 1'b0) begin n_fail++; $display("FAIL reg_first_empty: got %b expected 0", b_empty); end
        n_checks++; if (b_dout !== qb[0]) begin n_fail++; $display("FAIL reg_first_data: got %0h expected %0h", b_dout, qb[0]); end
        b_drive(1'b1, 32'h22, 1'b1);
        n_checks++; if (b_dout !== qb[0]) begin n_fail++; $display("FAIL reg_rw1_before: got %0h expected %0h", b_dout, qb[0]); end
        b_tick();
        n_checks++; if (b_dout !== qb[0]) begin n_fail++; $display("FAIL reg_rw1_data: got %0h expected %0h", b_dout, qb[0]); end
        n_checks++; if (b_count !== 3'(mb_cnt)) begin n_fail++; $display("FAIL reg_rw1_count: got %0d expected %0d", b_count, mb_cnt); end
        b_drive(1'b1, 32'h33, 1'b0); b_tick();
        b_drive(1'b1, 32'h44, 1'b0); b_tick();
        n_checks++; if ({b_full, b_af} !== 2'b11) begin n_fail++; $display("FAIL reg_full: got %b expected 11", {b_full, b_af}); end
        b_drive(1'b1, 32'h55, 1'b1);
        n_checks++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL reg_full_rw_ovf: got %b expected 1", b_ovf); end
        n_checks++; if (b_dout !== qb[0]) begin n_fail++; $display("FAIL reg_full_rw_data: got %0h expected %0h", b_dout, qb[0]); end
        b_tick();
        n_checks++; if (b_count !== 3'(mb_cnt)) begin n_fail++; $display("FAIL reg_full_rw_count: got %0d expected %0d", b_count, mb_cnt); end
        for (int i = 0; i < 2; i++) begin
            b_drive(1'b0, 32'h0, 1'b1);
            n_checks++; if (b_dout !== qb[0]) begin n_fail++; $display("FAIL reg_drain[%0d]: got %0h expected %0h", i, b_dout, qb[0]); end
            b_tick();
        end
        n_checks++; if ({b_empty, b_ae} !== 2'b11) begin n_fail++; $display("FAIL reg_drained: got %b expected 11", {b_empty, b_ae}); end
    endtask

    task automatic test_underflow();
        a_drive(1'b1, 32'h33, 1'b1);
        n_checks++; if (a_udf !== 1'b1) begin n_fail++; $display("FAIL udf_pulse: got %b expected 1", a_udf); end
        a_tick();
        n_checks++; if (a_udfs !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %b expected 1", a_udfs); end
        n_checks++; if (a_count !== 4'd1) begin n_fail++; $display("FAIL udf_count: got %0d expected 1", a_count); end
        n_checks++; if (a_dout !== 32'h33) begin n_fail++; $display("FAIL udf_data: got %0h expected 33", a_dout); end
        a_drive(1'b0, 32'h0, 1'b0);
        a_clr = 1'b1;
        a_tick();
        n_checks++; if (a_udfs !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b expected 0", a_udfs); end
        a_drive(1'b0, 32'h0, 1'b1);
        a_tick();
        a_drive(1'b0, 32'h0, 1'b1);
        a_clr = 1'b1;
        a_tick();
        n_checks++; if (a_udfs !== 1'b0) begin n_fail++; $display("FAIL udf_clear_priority: got %b expected 0", a_udfs); end
    endtask

    task automatic test_softreset();
        a_drive(1'b0, 32'h0, 1'b1); a_tick();
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b1, 32'hD0 + i, 1'b0); a_tick();
        end
        a_drive(1'b0, 32'h0, 1'b0);
        a_soft = 1'b1;
        n_checks++; if (a_count !== 4'd3) begin n_fail++; $display("FAIL soft_before: got %0d expected 3", a_count); end
        a_tick();
        n_checks++; if (a_count !== 4'd0) begin n_fail++; $display("FAIL soft_count: got %0d expected 0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL soft_empty: got %b expected 1", a_empty); end
        n_checks++; if ({a_ovfs, a_udfs} !== 2'b00) begin n_fail++; $display("FAIL soft_sticky: got %b expected 00", {a_ovfs, a_udfs}); end
    endtask

    task automatic test_async_reset();
        a_drive(1'b0, 32'h0, 1'b1); a_tick();
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b1, 32'hE0 + i, 1'b0); a_tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        qa.delete(); ma_cnt = 0;
        qb.delete(); mb_cnt = 0;
        n_checks++; if (a_count !== 4'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL async_empty: got %b expected 1", a_empty); end
        n_checks++; if (a_udfs !== 1'b0) begin n_fail++; $display("FAIL async_sticky: got %b expected 0", a_udfs); end
        @(negedge clk);
        rst_n = 1'b1;
        a_drive(1'b1, 32'hF0, 1'b0);
        a_tick();
        n_checks++; if (a_dout !== qa[0]) begin n_fail++; $display("FAIL async_resume: got %0h expected %0h", a_dout, qa[0]); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; ma_cnt = 0; mb_cnt = 0;
        rst_n = 1'b0;
        a_soft = 1'b0; a_vin = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = '0;
        b_soft = 1'b0; b_vin = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;
        a_afthr = 4'd4; a_aethr = 4'd1;
        b_afthr = 3'd2; b_aethr = 3'd0;
        test_reset();
        test_fill_overflow();
        test_drain();
        test_back_to_back();
        test_regout();
        test_underflow();
        test_softreset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
